// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

    // Arbiter FSM: idle, or bus owned by master 0 / master 1.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Master indices: 0 = instruction fetch, 1 = data memory controller.
    localparam logic M_FETCH = 1'b0;
    localparam logic M_DATA  = 1'b1;

endpackage

// File: rtl/bus_watchdog.sv
// Slave-response watchdog: counts stalled strobe cycles and flags expiry
// once TIMEOUT cycles have passed without an ack. Saturates, never wraps.
module bus_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic cnt_en,
    output logic expired
);

    localparam int                CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q;

    // Stall counter: clear has priority, then count up to LIMIT and hold.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (cnt_en && (count_q != LIMIT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto a single shared slave bus, with a
// watchdog that aborts a granted cycle whose slave never acknowledges.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WORD    = 16,
    parameter int TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // master 0: instruction fetch
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [1:0]      m0_sel_i,
    input  logic [WORD-1:0] m0_adr_i,
    input  logic [WORD-1:0] m0_dat_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic [WORD-1:0] m0_dat_o,
    // master 1: data memory controller
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [1:0]      m1_sel_i,
    input  logic [WORD-1:0] m1_adr_i,
    input  logic [WORD-1:0] m1_dat_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [WORD-1:0] m1_dat_o,
    // shared slave bus
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [1:0]      sel_o,
    output logic [WORD-1:0] adr_o,
    output logic [WORD-1:0] dat_o,
    input  logic            ack_i,
    input  logic [WORD-1:0] dat_i,
    output logic [1:0]      gnt_o
);

    arb_state_t state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic       busy;       // some master owns the bus
    logic       owner;      // index of the owning master (valid when busy)
    logic       req_cyc;    // owner's cyc, 0 when idle
    logic       req_stb;    // owner's stb, 0 when idle
    logic       abort;      // watchdog kills the current cycle
    logic       ack_eff;    // ack_i qualified by an active slave cycle
    logic       wd_clr;
    logic       wd_en;
    logic       wd_expired;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (wd_clr),
        .cnt_en  (wd_en),
        .expired (wd_expired)
    );

    // FSM state and round-robin pointer; after reset master 1 counts as last
    // granted so master 0 wins the first contested arbitration.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= M_DATA;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Next state: arbitrate from IDLE, release on cyc drop or watchdog abort.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = (last_gnt_q == M_DATA) ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!req_cyc || abort) begin
                    state_d    = IDLE;
                    last_gnt_d = owner;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave-side mux plus ack/err/data routing back to the owning master.
    always_comb begin
        busy    = (state_q == GNT0) || (state_q == GNT1);
        owner   = (state_q == GNT1) ? M_DATA : M_FETCH;
        req_cyc = busy && ((owner == M_DATA) ? m1_cyc_i : m0_cyc_i);
        req_stb = busy && ((owner == M_DATA) ? m1_stb_i : m0_stb_i);

        // An ack arriving in the expiry cycle rescues the transfer.
        abort   = req_cyc && wd_expired && !ack_i;
        cyc_o   = req_cyc && !abort;
        stb_o   = req_stb && !abort;

        we_o  = 1'b0;
        sel_o = '0;
        adr_o = '0;
        dat_o = '0;
        if (busy) begin
            if (owner == M_DATA) begin
                we_o  = m1_we_i;
                sel_o = m1_sel_i;
                adr_o = m1_adr_i;
                dat_o = m1_dat_i;
            end else begin
                we_o  = m0_we_i;
                sel_o = m0_sel_i;
                adr_o = m0_adr_i;
                dat_o = m0_dat_i;
            end
        end

        gnt_o = {busy && (owner == M_DATA), busy && (owner == M_FETCH)};

        ack_eff  = ack_i && cyc_o;
        m0_ack_o = ack_eff && (owner == M_FETCH);
        m1_ack_o = ack_eff && (owner == M_DATA);
        m0_err_o = abort && (owner == M_FETCH);
        m1_err_o = abort && (owner == M_DATA);
        m0_dat_o = (busy && (owner == M_FETCH)) ? dat_i : '0;
        m1_dat_o = (busy && (owner == M_DATA))  ? dat_i : '0;

        // Idle keeps the counter at zero, so every new grant starts fresh.
        wd_clr = !busy || ack_eff;
        wd_en  = stb_o && !ack_i;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration, routing, watchdog, reset.
module tb_mem_bus_arbiter;

    localparam int WORD    = 16;
    localparam int TIMEOUT = 15;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            m0_cyc_i, m0_stb_i, m0_we_i;
    logic [1:0]      m0_sel_i;
    logic [WORD-1:0] m0_adr_i, m0_dat_i;
    logic            m0_ack_o, m0_err_o;
    logic [WORD-1:0] m0_dat_o;
    logic            m1_cyc_i, m1_stb_i, m1_we_i;
    logic [1:0]      m1_sel_i;
    logic [WORD-1:0] m1_adr_i, m1_dat_i;
    logic            m1_ack_o, m1_err_o;
    logic [WORD-1:0] m1_dat_o;
    logic            cyc_o, stb_o, we_o;
    logic [1:0]      sel_o;
    logic [WORD-1:0] adr_o, dat_o;
    logic            ack_i;
    logic [WORD-1:0] dat_i;
    logic [1:0]      gnt_o;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(
        .WORD    (WORD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_we_i  (m0_we_i),
        .m0_sel_i (m0_sel_i),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m0_dat_o (m0_dat_o),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_we_i  (m1_we_i),
        .m1_sel_i (m1_sel_i),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .m1_dat_o (m1_dat_o),
        .cyc_o    (cyc_o),
        .stb_o    (stb_o),
        .we_o     (we_o),
        .sel_o    (sel_o),
        .adr_o    (adr_o),
        .dat_o    (dat_o),
        .ack_i    (ack_i),
        .dat_i    (dat_i),
        .gnt_o    (gnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_sel_i = 2'b00;
        m0_adr_i = '0;   m0_dat_i = '0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_sel_i = 2'b00;
        m1_adr_i = '0;   m1_dat_i = '0;
        ack_i    = 1'b0; dat_i    = '0;
    endtask

    // Every DUT output must read zero.
    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, 32'({cyc_o, stb_o, we_o, sel_o, gnt_o,
                                  m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 0);
        check({tag, "_adr"},    32'(adr_o),    0);
        check({tag, "_dat"},    32'(dat_o),    0);
        check({tag, "_m0_dat"}, 32'(m0_dat_o), 0);
        check({tag, "_m1_dat"}, 32'(m1_dat_o), 0);
    endtask

    initial begin
        // ---- reset: outputs quiet even with a request and ack present
        clear_inputs();
        rst_i    = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 16'h0040; m0_sel_i = 2'b11;
        ack_i    = 1'b1; dat_i = 16'hFFFF;
        #12;
        check_quiet("reset");
        clear_inputs();
        rst_i = 1'b0;
        tick();

        // ---- m0 read at 0x0040, ack on third granted cycle
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 16'h0040; m0_sel_i = 2'b11;
        #1;
        check("rd_latency_gnt", 32'(gnt_o), 0);
        check("rd_latency_cyc", 32'(cyc_o), 0);
        tick();
        check("rd_gnt",  32'(gnt_o), 'h1);
        check("rd_cyc",  32'({cyc_o, stb_o, we_o}), 'b110);
        check("rd_adr",  32'(adr_o), 'h0040);
        check("rd_noack0", 32'(m0_ack_o), 0);
        tick();
        check("rd_noack1", 32'(m0_ack_o), 0);
        tick();
        ack_i = 1'b1; dat_i = 16'hBEEF;
        #1;
        check("rd_m0_ack", 32'(m0_ack_o), 1);
        check("rd_m0_dat", 32'(m0_dat_o), 'hBEEF);
        check("rd_m1_ack", 32'(m1_ack_o), 0);
        check("rd_m1_dat", 32'(m1_dat_o), 0);
        tick();
        clear_inputs();
        #1;
        check("rd_release_cyc", 32'(cyc_o), 0);
        tick();
        check("rd_idle_gnt", 32'(gnt_o), 0);

        // ---- fresh reset, then simultaneous requests: m0 first
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_sel_i = 2'b11;
        m0_adr_i = 16'h0100; m0_dat_i = 16'h5555;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_sel_i = 2'b01;
        m1_adr_i = 16'h1234; m1_dat_i = 16'h00AA;
        #1;
        check("rr_idle_gnt", 32'(gnt_o), 0);
        tick();
        check("rr_first_gnt", 32'(gnt_o), 'h1);
        check("rr_first_adr", 32'(adr_o), 'h0100);
        ack_i = 1'b1; dat_i = 16'h0F0F;
        #1;
        check("rr_m0_ack", 32'(m0_ack_o), 1);
        check("rr_m1_ack", 32'(m1_ack_o), 0);
        check("rr_m1_dat", 32'(m1_dat_o), 0);
        tick();
        ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        check("rr_drop_gnt", 32'(gnt_o), 'h1);
        check("rr_drop_cyc", 32'(cyc_o), 0);
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;   // m0 requests again while waiting
        #1;
        check("rr_gap_gnt", 32'(gnt_o), 0);
        tick();
        check("rr_second_gnt", 32'(gnt_o), 'h2);

        // ---- m1 write on the bus, m0 still requesting
        check("wr_ctl", 32'({cyc_o, stb_o, we_o}), 'b111);
        check("wr_sel", 32'(sel_o), 'b01);
        check("wr_adr", 32'(adr_o), 'h1234);
        check("wr_dat", 32'(dat_o), 'h00AA);
        ack_i = 1'b1; dat_i = 16'h7777;
        #1;
        check("wr_m1_ack", 32'(m1_ack_o), 1);
        check("wr_m1_dat", 32'(m1_dat_o), 'h7777);
        check("wr_m0_ack", 32'(m0_ack_o), 0);
        check("wr_m0_dat", 32'(m0_dat_o), 0);
        tick();
        ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        check("b2b_idle_gnt", 32'(gnt_o), 0);
        tick();
        check("b2b_m0_gnt", 32'(gnt_o), 'h1);
        check("b2b_m0_adr", 32'(adr_o), 'h0100);
        clear_inputs();
        tick();

        // ---- watchdog expiry: no ack ever
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 16'h0200;
        tick();
        for (int k = 0; k < TIMEOUT; k++) begin
            check($sformatf("wd_no_err_c%0d", k), 32'({m0_err_o, cyc_o}), 'b01);
            tick();
        end
        check("wd_err",     32'(m0_err_o), 1);
        check("wd_cyc_stb", 32'({cyc_o, stb_o}), 0);
        check("wd_m0_ack",  32'(m0_ack_o), 0);
        check("wd_m1_err",  32'(m1_err_o), 0);
        tick();
        check("wd_idle_gnt", 32'(gnt_o), 0);
        check("wd_err_pulse", 32'(m0_err_o), 0);
        ack_i = 1'b1;
        #1;
        check("wd_idle_ack_ignored", 32'({m0_ack_o, m1_ack_o}), 0);
        tick();
        ack_i = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) tick();
        ack_i = 1'b1; dat_i = 16'h1357;
        #1;
        check("wd_late_ack", 32'(m0_ack_o), 1);
        check("wd_late_no_err", 32'(m0_err_o), 0);
        check("wd_late_cyc", 32'(cyc_o), 1);
        check("wd_late_dat", 32'(m0_dat_o), 'h1357);
        tick();
        ack_i = 1'b0;
        #1;
        check("wd_after_ack", 32'({gnt_o, m0_err_o}), 'b010);
        clear_inputs();
        tick();

        // ---- reset during an m1 write
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_sel_i = 2'b10;
        m1_adr_i = 16'h2222; m1_dat_i = 16'h3333;
        tick();
        check("rst_m1_gnt", 32'(gnt_o), 'h2);
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 16'h0300;
        ack_i = 1'b1; dat_i = 16'h4444;
        #1;
        check("rst_m1_ack_before", 32'(m1_ack_o), 1);
        #1;
        rst_i = 1'b1;
        #1;
        check_quiet("rst_mid");
        tick();
        check_quiet("rst_held");
        #2;
        rst_i = 1'b0;
        ack_i = 1'b0;
        #1;
        check("rst_release_gnt", 32'(gnt_o), 0);
        tick();
        check("rst_m0_first", 32'(gnt_o), 'h1);
        check("rst_m0_adr",   32'(adr_o), 'h0300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
